// File: rtl/trace_win_pkg.sv
// Shared types and default widths for the trace capture-window sequencer.
// Contents: the sequencer state enum, the default counter/index widths, the
// shadow-config struct latched on arm, and a helper that maps a repeat count
// of 0 to 1.
package trace_win_pkg;

    localparam int unsigned CNT_W  = 16;
    localparam int unsigned WIN_W  = 8;
    localparam int unsigned SCNT_W = 24;

    typedef enum logic [2:0] {
        StIdle,
        StArmed,
        StDelay,
        StOn,
        StOff,
        StDone
    } state_e;

    typedef struct packed {
        logic [CNT_W-1:0] start_dly;
        logic [CNT_W-1:0] on_len;
        logic [CNT_W-1:0] off_len;
        logic [WIN_W-1:0] repeat_cnt;
    } shadow_cfg_t;

    // A repeat count of zero still runs one window.
    function automatic logic [WIN_W-1:0] eff_repeat(input logic [WIN_W-1:0] r);
        return (r == '0) ? WIN_W'(1) : r;
    endfunction

endpackage

// File: rtl/trace_win_if.sv
// Control/status bundle between a trace host and trace_window_ctrl.
// master: drives arm, abort, trig and cfg_*; observes capture_en, busy, done,
//         win_idx and sample_cnt.
// slave : the sequencer side (inputs and outputs mirrored).
interface trace_win_if #(
    parameter int unsigned CNT_W  = trace_win_pkg::CNT_W,
    parameter int unsigned WIN_W  = trace_win_pkg::WIN_W,
    parameter int unsigned SCNT_W = trace_win_pkg::SCNT_W
) ();

    logic              arm;
    logic              abort;
    logic              trig;
    logic [CNT_W-1:0]  cfg_start_dly;
    logic [CNT_W-1:0]  cfg_on_len;
    logic [CNT_W-1:0]  cfg_off_len;
    logic [WIN_W-1:0]  cfg_repeat;
    logic              capture_en;
    logic              busy;
    logic              done;
    logic [WIN_W-1:0]  win_idx;
    logic [SCNT_W-1:0] sample_cnt;

    modport master (
        output arm, abort, trig, cfg_start_dly, cfg_on_len, cfg_off_len, cfg_repeat,
        input  capture_en, busy, done, win_idx, sample_cnt
    );

    modport slave (
        input  arm, abort, trig, cfg_start_dly, cfg_on_len, cfg_off_len, cfg_repeat,
        output capture_en, busy, done, win_idx, sample_cnt
    );

endinterface

// File: rtl/trace_win_cnt.sv
// Loadable down-counter with zero flag, shared by the DELAY/ON/OFF phases.
// Ports:
//   clk, rst_n  - clock, asynchronous active-low reset
//   load        - load load_val this cycle (takes priority over counting)
//   load_val    - value to load (phase length minus one)
//   zero        - count is zero, i.e. the current cycle is the last of its phase
// The counter stops at zero rather than wrapping.
module trace_win_cnt #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         zero
);

    logic [W-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= load_val;
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - W'(1);
        end
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/trace_window_ctrl.sv
// Capture-window sequencer: after arm (and, with TRACE_WIN_TRIG_EN defined, a
// trigger) waits start_dly cycles, then runs repeat windows of on_len cycles of
// capture_en=1 separated by off_len cycles of capture_en=0, then pulses done.
// Ports:
//   clk, rst_n - clock, asynchronous active-low reset
//   bus        - trace_win_if slave: arm/abort/trig/cfg_* in;
//                capture_en/busy/done/win_idx/sample_cnt out
// Build option: TRACE_WIN_TRIG_EN - ARMED waits for trig=1; otherwise ARMED
// lasts one cycle and trig is ignored.
module trace_window_ctrl #(
    parameter int unsigned CNT_W  = trace_win_pkg::CNT_W,
    parameter int unsigned WIN_W  = trace_win_pkg::WIN_W,
    parameter int unsigned SCNT_W = trace_win_pkg::SCNT_W
) (
    input  logic          clk,
    input  logic          rst_n,
    trace_win_if.slave    bus
);

    import trace_win_pkg::*;

    // The shadow struct is sized by the package widths.
    if (CNT_W != trace_win_pkg::CNT_W || WIN_W != trace_win_pkg::WIN_W ||
        SCNT_W != trace_win_pkg::SCNT_W) begin : g_width_chk
        $error("trace_window_ctrl widths must match trace_win_pkg");
    end

    state_e            state_q, state_d;
    shadow_cfg_t       shd_q;
    logic              latch_cfg;
    logic [WIN_W-1:0]  win_idx_q, win_idx_d;
    logic [SCNT_W-1:0] sample_cnt_q, sample_cnt_d, sample_inc;
    logic              cap_q;
    logic              cnt_load;
    logic [CNT_W-1:0]  cnt_load_val;
    logic              cnt_zero;
    logic              go;
    logic [WIN_W-1:0]  repeat_eff;
    logic [WIN_W:0]    next_idx;
    logic              more_win;

`ifdef TRACE_WIN_TRIG_EN
    assign go = bus.trig;
`else
    logic trig_unused;
    assign trig_unused = bus.trig;
    assign go = 1'b1;
`endif

    assign repeat_eff = eff_repeat(shd_q.repeat_cnt);
    assign next_idx   = {1'b0, win_idx_q} + (WIN_W+1)'(1);
    assign more_win   = (next_idx < {1'b0, repeat_eff});

    // Saturating increment on every ON cycle, including one that is aborted.
    assign sample_inc = (state_q == StOn && sample_cnt_q != '1) ?
                        sample_cnt_q + SCNT_W'(1) : sample_cnt_q;

    trace_win_cnt #(
        .W (CNT_W)
    ) u_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (cnt_load),
        .load_val (cnt_load_val),
        .zero     (cnt_zero)
    );

    always_comb begin
        state_d      = state_q;
        win_idx_d    = win_idx_q;
        sample_cnt_d = sample_inc;
        latch_cfg    = 1'b0;
        cnt_load     = 1'b0;
        cnt_load_val = '0;

        case (state_q)
            StIdle: begin
                if (bus.arm) begin
                    state_d      = StArmed;
                    latch_cfg    = 1'b1;
                    win_idx_d    = '0;
                    sample_cnt_d = '0;
                end
            end
            StArmed: begin
                if (go) begin
                    if (shd_q.on_len == '0 && shd_q.start_dly == '0) begin
                        state_d = StDone;
                    end else if (shd_q.start_dly == '0) begin
                        state_d      = StOn;
                        cnt_load     = 1'b1;
                        cnt_load_val = shd_q.on_len - CNT_W'(1);
                    end else begin
                        state_d      = StDelay;
                        cnt_load     = 1'b1;
                        cnt_load_val = shd_q.start_dly - CNT_W'(1);
                    end
                end
            end
            StDelay: begin
                if (cnt_zero) begin
                    if (shd_q.on_len == '0) begin
                        state_d = StDone;
                    end else begin
                        state_d      = StOn;
                        cnt_load     = 1'b1;
                        cnt_load_val = shd_q.on_len - CNT_W'(1);
                    end
                end
            end
            StOn: begin
                if (cnt_zero) begin
                    if (more_win) begin
                        win_idx_d = next_idx[WIN_W-1:0];
                        cnt_load  = 1'b1;
                        // Zero-length gap: reload ON so capture_en never drops.
                        if (shd_q.off_len == '0) begin
                            state_d      = StOn;
                            cnt_load_val = shd_q.on_len - CNT_W'(1);
                        end else begin
                            state_d      = StOff;
                            cnt_load_val = shd_q.off_len - CNT_W'(1);
                        end
                    end else begin
                        state_d = StDone;
                    end
                end
            end
            StOff: begin
                if (cnt_zero) begin
                    state_d      = StOn;
                    cnt_load     = 1'b1;
                    cnt_load_val = shd_q.on_len - CNT_W'(1);
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // Abort overrides everything, including an arm in the same cycle.
        if (bus.abort) begin
            state_d      = StIdle;
            win_idx_d    = win_idx_q;
            sample_cnt_d = sample_inc;
            latch_cfg    = 1'b0;
            cnt_load     = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            shd_q        <= '0;
            win_idx_q    <= '0;
            sample_cnt_q <= '0;
            cap_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            win_idx_q    <= win_idx_d;
            sample_cnt_q <= sample_cnt_d;
            cap_q        <= (state_d == StOn);
            if (latch_cfg) begin
                shd_q <= '{start_dly:  bus.cfg_start_dly,
                           on_len:     bus.cfg_on_len,
                           off_len:    bus.cfg_off_len,
                           repeat_cnt: bus.cfg_repeat};
            end
        end
    end

    assign bus.capture_en = cap_q;
    assign bus.busy       = (state_q != StIdle);
    assign bus.done       = (state_q == StDone);
    assign bus.win_idx    = win_idx_q;
    assign bus.sample_cnt = sample_cnt_q;

endmodule

// File: doc/trace_window_ctrl.md
Name: trace_window_ctrl

Overview:
- Synthesizable capture-window sequencer; hardware counterpart of the dump-on/dump-off control used in simulation benches.
- After arm (and optionally a trigger), waits a programmable delay, then drives capture_en high for ON cycles and low for OFF cycles, repeated for a programmed window count.
- Sits in front of trace buffers and signal-probe muxes and gates their write-enable.

Parameters:
- CNT_W, 16, width of the delay, on-length and off-length counters and config fields
- WIN_W, 8, width of the repeat count and window index
- SCNT_W, 24, width of the saturating captured-sample counter

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- arm  in  1  start a sequence; honoured only in IDLE
- abort  in  1  cancel from any state
- trig  in  1  external trigger; used only with TRACE_WIN_TRIG_EN
- cfg_start_dly  in  CNT_W  cycles from trigger (or arm) to first ON
- cfg_on_len  in  CNT_W  ON cycles per window
- cfg_off_len  in  CNT_W  OFF cycles between windows
- cfg_repeat  in  WIN_W  number of ON windows; 0 is treated as 1
- capture_en  out  1  registered; high exactly during ON
- busy  out  1  high in any state other than IDLE
- done  out  1  one-cycle pulse on normal completion
- win_idx  out  WIN_W  index of the current/last window, 0-based
- sample_cnt  out  SCNT_W  total ON cycles since last arm; saturates at all-ones

Behaviour:
- Reset values: state IDLE, capture_en 0, busy 0, done 0, win_idx 0, sample_cnt 0, all counters 0.
- arm in IDLE:
  - Latches all cfg_* into shadow registers.
  - Clears win_idx and sample_cnt.
  - Next state is ARMED.
  - cfg_* changes after arm have no effect until the next arm.
- States: IDLE, ARMED, DELAY, ON, OFF, DONE.
- ARMED -> DELAY on trig=1 (macro on) or unconditionally on the next cycle (macro off). If dly=0, go directly to ON instead of DELAY.
- DELAY lasts exactly dly cycles, then ON.
- on_len=0: ARMED/DELAY go directly to DONE. capture_en never asserts; done still pulses.
- ON lasts exactly on_len cycles. capture_en=1 on each of them; sample_cnt increments each ON cycle, saturating.
- End of ON:
  - If win_idx+1 < repeat, win_idx increments and the next state is OFF.
  - If off_len=0, the next state is ON directly; capture_en stays high continuously.
  - Otherwise the next state is DONE.
- OFF lasts exactly off_len cycles, then ON.
- DONE lasts 1 cycle with done=1, then IDLE. busy is 0 from IDLE onward.
- abort has priority over all transitions:
  - Next state is IDLE; capture_en=0 the following cycle.
  - done is not pulsed; win_idx and sample_cnt hold their values.
- arm while busy is ignored. arm and abort together in IDLE: abort wins, stays IDLE.
- arm and trig in the same IDLE cycle: trig is ignored. The trigger must arrive while in ARMED.
- Reset mid-sequence: immediate return to reset values, asynchronously.
- Counters are down-counters loaded with (len-1). There is no wrap-around at CNT_W all-ones: a length of 2^CNT_W-1 yields exactly that many cycles.

Optional Feature:
- TRACE_WIN_TRIG_EN defined: ARMED waits indefinitely for trig=1 (level, sampled each clock).
- Not defined: trig is unused; ARMED always lasts 1 cycle and the sequence free-runs from arm. The port is retained in both builds.

Decomposition:
- Package trace_win_pkg holds:
  - state enum typedef (IDLE..DONE)
  - default widths CNT_W/WIN_W/SCNT_W as localparams
  - a shadow-config struct typedef
- One natural sub-module: trace_win_cnt, a loadable down-counter with a zero flag, instanced once and shared by DELAY/ON/OFF. The FSM reloads it on each state entry.

Test Plan:
- Basic: dly=3, on=4, off=2, repeat=2, arm at cycle 0, macro off.
  - capture_en high cycles 5-8 and 11-14.
  - done at cycle 15; sample_cnt=8; win_idx=1.
- Trigger: macro on, arm at 0, trig at 10, dly=0, on=2, repeat=1.
  - capture_en high cycles 11-12.
  - no capture before trig, even if ARMED for 10 cycles.
- Back-to-back: off=0, on=3, repeat=3.
  - capture_en continuously high for 9 cycles; done pulses once; sample_cnt=9.
- Abort mid-ON: dly=0, on=50, abort at third ON cycle.
  - capture_en low next cycle; busy 0; no done; sample_cnt=3.
- Edge configs:
  - on=0 gives done with sample_cnt=0.
  - repeat=0 behaves as repeat=1.
  - arm while busy is ignored.
  - cfg change after arm is not applied.
- Reset: rst_n low during OFF, asynchronous to clk.
  - All outputs are reset values before the next edge.
  - A new arm after release runs a clean sequence.
